// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: RISC-V load/store funct3 codes, FSM
// state encoding, and the size/alignment helpers.
package mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_BAD = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Byte-enable pattern for an access of size funct3[1:0] at lane 0.
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   return 8'h01;
         2'b01:   return 8'h03;
         2'b10:   return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic access_bad(input logic [2:0] f3, input logic [2:0] off);
      logic mis;
      case (f3[1:0])
         2'b00:   mis = 1'b0;
         2'b01:   mis = off[0];
         2'b10:   mis = |off[1:0];
         default: mis = |off;
      endcase
      return (f3 == F3_BAD) || mis;
   endfunction

endpackage

// File: rtl/load_align_ext.sv
// Shifts the addressed lane of a raw doubleword down to bit 0 and
// sign/zero-extends it according to the load funct3.
module load_align_ext
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data
);

   logic [XLEN-1:0] lane;

   assign lane = rdata >> {off, 3'b000};

   always_comb begin
      data = lane;
      case (funct3)
         F3_LB:   data = {{(XLEN-8){lane[7]}}, lane[7:0]};
         F3_LH:   data = {{(XLEN-16){lane[15]}}, lane[15:0]};
         F3_LW:   data = {{(XLEN-32){lane[31]}}, lane[31:0]};
         F3_LD:   data = lane;
         F3_LBU:  data = {{(XLEN-8){1'b0}}, lane[7:0]};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, lane[15:0]};
         F3_LWU:  data = {{(XLEN-32){1'b0}}, lane[31:0]};
         default: data = lane;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 64-bit RISC-V pipeline: issues loads/stores over a
// req/ready + rvalid handshake and registers the Write_Back interface.
module mem_access_stage
   import mem_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [XLEN-1:0]   ex_Result,
   input  logic [XLEN-1:0]   ex_StoreData,
   input  logic              ex_MemRead,
   input  logic              ex_MemWrite,
   input  logic              ex_Mem_to_Reg,
   input  logic              ex_regWrite,
   input  logic [2:0]        ex_funct3,
   input  logic [REG_AW-1:0] ex_rd,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [XLEN-1:0]   dmem_addr,
   output logic [XLEN-1:0]   dmem_wdata,
   output logic [7:0]        dmem_wstrb,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   input  logic [XLEN-1:0]   dmem_rdata,
   output logic [XLEN-1:0]   Result,
   output logic [XLEN-1:0]   ReadData,
   output logic              Mem_to_Reg,
   output logic              regWrite_receive,
   output logic [REG_AW-1:0] rd,
   output logic              mem_err
);

   state_t            state;
   logic              req_q;
   logic              we_p0;
   logic [XLEN-1:0]   addr_p0;
   logic [XLEN-1:0]   wdata_p0;
   logic [7:0]        wstrb_p0;
   logic [2:0]        f3_p0;
   logic [REG_AW-1:0] rd_p0;
   logic              m2r_p0;
   logic              regw_p0;

   logic              is_mem;
   logic              bad;
   logic              launch;
   logic [XLEN-1:0]   st_data;
   logic [7:0]        st_strb;
   logic [XLEN-1:0]   ld_data;

   assign is_mem = ex_valid & (ex_MemRead | ex_MemWrite);
   assign bad    = access_bad(ex_funct3, ex_Result[2:0]);
   assign launch = (state == ST_IDLE) & is_mem & ~bad;

   always_comb begin
      case (ex_funct3[1:0])
         2'b00:   st_data = {8{ex_StoreData[7:0]}};
         2'b01:   st_data = {4{ex_StoreData[15:0]}};
         2'b10:   st_data = {2{ex_StoreData[31:0]}};
         default: st_data = ex_StoreData;
      endcase
   end

   assign st_strb = size_mask(ex_funct3[1:0]) << ex_Result[2:0];

   // Stall covers the launch cycle through the cycle before the access completes.
   always_comb begin
      case (state)
         ST_IDLE: stall = launch;
         ST_REQ:  stall = ~(we_p0 & dmem_ready);
         ST_RESP: stall = ~dmem_rvalid;
         default: stall = 1'b0;
      endcase
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_p0;
   assign dmem_addr  = {addr_p0[XLEN-1:3], 3'b000};
   assign dmem_wdata = wdata_p0;
   assign dmem_wstrb = we_p0 ? wstrb_p0 : 8'h00;

   load_align_ext #(.XLEN(XLEN)) u_load_align (
      .rdata  (dmem_rdata),
      .off    (addr_p0[2:0]),
      .funct3 (f3_p0),
      .data   (ld_data)
   );

   // p0: instruction captured on leaving IDLE, held for the whole access
   always_ff @(posedge clk) begin
      if (launch) begin
         addr_p0  <= ex_Result;
         wdata_p0 <= st_data;
         wstrb_p0 <= st_strb;
         f3_p0    <= ex_funct3;
         rd_p0    <= ex_rd;
         m2r_p0   <= ex_Mem_to_Reg;
         regw_p0  <= ex_regWrite;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         req_q            <= 1'b0;
         we_p0            <= 1'b0;
         Result           <= '0;
         ReadData         <= '0;
         Mem_to_Reg       <= 1'b0;
         regWrite_receive <= 1'b0;
         rd               <= '0;
         mem_err          <= 1'b0;
      end else begin
         regWrite_receive <= 1'b0;
         mem_err          <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  state <= ST_REQ;
                  req_q <= 1'b1;
                  we_p0 <= ex_MemWrite;
               end else if (ex_valid) begin
                  Result     <= ex_Result;
                  ReadData   <= '0;
                  Mem_to_Reg <= ex_Mem_to_Reg;
                  rd         <= ex_rd;
                  if (is_mem) mem_err <= 1'b1;
                  else        regWrite_receive <= ex_regWrite;
               end
            end
            ST_REQ: begin
               if (dmem_ready) begin
                  req_q <= 1'b0;
                  if (we_p0) begin
                     state            <= ST_IDLE;
                     Result           <= addr_p0;
                     ReadData         <= '0;
                     Mem_to_Reg       <= m2r_p0;
                     rd               <= rd_p0;
                     regWrite_receive <= regw_p0;
                  end else begin
                     state <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (dmem_rvalid) begin
                  state            <= ST_IDLE;
                  Result           <= addr_p0;
                  ReadData         <= ld_data;
                  Mem_to_Reg       <= m2r_p0;
                  rd               <= rd_p0;
                  regWrite_receive <= regw_p0;
               end
            end
            default: begin
               state <= ST_IDLE;
               req_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
